// File: rtl/sys_ram_model.sv
// Latency-programmable 32-bit word RAM: every request stalls LAT BUSY cycles, then completes in one ACCESS cycle.
// Optional build macro RAM_ALIGN_CHECK_EN flags misaligned requests as ERROR instead of hitting the containing word.
module sys_ram_model #(
  parameter int ADDR_W = 14,
  parameter int LAT    = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] memaddr,
  input  logic [31:0] memstore,
  input  logic        memREN,
  input  logic        memWEN,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  typedef enum logic [1:0] {
    RAM_FREE   = 2'd0,
    RAM_BUSY   = 2'd1,
    RAM_ACCESS = 2'd2,
    RAM_ERROR  = 2'd3
  } ramstate_t;

  localparam logic [3:0] LAT_C = 4'(LAT);

  if (LAT < 0 || LAT > 15) begin : g_lat_illegal
    $error("sys_ram_model: LAT must be in 0..15");
  end

  logic [31:0]       r_mem [0:(1 << ADDR_W) - 1];
  logic [3:0]        r_cnt;
  logic [33:0]       r_key;

  logic [33:0]       w_req;
  logic              w_match;
  logic [3:0]        w_eff;
  logic [ADDR_W-1:0] w_word;
  logic              w_hi_err;
  logic              w_align_err;
  ramstate_t         w_state;

  // Saturating count step so a long stall never wraps back to a matching value.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'd15) ? 4'd15 : v + 4'd1;
  endfunction

  assign w_req   = {memaddr, memREN, memWEN};
  assign w_match = (w_req == r_key);
  assign w_eff   = w_match ? r_cnt : 4'd0;
  assign w_word  = memaddr[ADDR_W+1:2];

  if (ADDR_W < 30) begin : g_hi_chk
    assign w_hi_err = |memaddr[31:ADDR_W+2];
  end else begin : g_hi_none
    assign w_hi_err = 1'b0;
  end

`ifdef RAM_ALIGN_CHECK_EN
  assign w_align_err = |memaddr[1:0];
`else
  assign w_align_err = 1'b0;
`endif

  // Combinational status decode; reset forces FREE so a pending write can never commit.
  always_comb begin
    w_state = RAM_FREE;
    if (!nRST) begin
      w_state = RAM_FREE;
    end else if (memREN && memWEN) begin
      w_state = RAM_ERROR;
    end else if (!memREN && !memWEN) begin
      w_state = RAM_FREE;
    end else if (w_hi_err || w_align_err) begin
      w_state = RAM_ERROR;
    end else if (w_eff == LAT_C) begin
      w_state = RAM_ACCESS;
    end else begin
      w_state = RAM_BUSY;
    end
  end

  // Read data is only driven during a read ACCESS cycle.
  always_comb begin
    ramload = 32'd0;
    if (w_state == RAM_ACCESS && memREN) begin
      ramload = r_mem[w_word];
    end else begin
      ramload = 32'd0;
    end
  end

  assign ramstate = w_state;

  // Latency counter and request key; anything other than BUSY discards the count.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt <= 4'd0;
      r_key <= 34'd0;
    end else begin
      case (w_state)
        RAM_BUSY: begin
          r_cnt <= sat_inc(w_eff);
          r_key <= w_req;
        end
        default: begin
          r_cnt <= 4'd0;
          r_key <= 34'd0;
        end
      endcase
    end
  end

  // Storage array is intentionally not reset; writes commit only on a write ACCESS edge.
  always_ff @(posedge CLK) begin
    if (w_state == RAM_ACCESS && memWEN) begin
      r_mem[w_word] <= memstore;
    end
  end

endmodule

// File: tb/tb_sys_ram_model.sv
// Directed bench for sys_ram_model: one LAT=2 instance and one LAT=0 instance, checked cycle by cycle.
module tb_sys_ram_model;

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

  logic        clk;
  logic        nrst;
  logic [31:0] a_addr, a_store, a_load;
  logic        a_ren, a_wen;
  logic [1:0]  a_state;
  logic [31:0] z_addr, z_store, z_load;
  logic        z_ren, z_wen;
  logic [1:0]  z_state;

  int checks = 0;
  int errors = 0;

  sys_ram_model #(.ADDR_W(14), .LAT(2)) dut (
    .CLK(clk), .nRST(nrst), .memaddr(a_addr), .memstore(a_store),
    .memREN(a_ren), .memWEN(a_wen), .ramload(a_load), .ramstate(a_state)
  );

  sys_ram_model #(.ADDR_W(14), .LAT(0)) dut0 (
    .CLK(clk), .nRST(nrst), .memaddr(z_addr), .memstore(z_store),
    .memREN(z_ren), .memWEN(z_wen), .ramload(z_load), .ramstate(z_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive the LAT=2 instance for one cycle and check its outputs mid-cycle.
  task automatic a_cyc(input string tag, input logic [31:0] addr, input logic [31:0] store,
                       input logic ren, input logic wen, input logic [1:0] exp_s,
                       input logic [31:0] exp_l);
    @(negedge clk);
    a_addr = addr; a_store = store; a_ren = ren; a_wen = wen;
    #1;
    chk({tag, ".state"}, {30'd0, a_state}, {30'd0, exp_s});
    chk({tag, ".load"}, a_load, exp_l);
  endtask

  // Same for the LAT=0 instance.
  task automatic z_cyc(input string tag, input logic [31:0] addr, input logic [31:0] store,
                       input logic ren, input logic wen, input logic [1:0] exp_s,
                       input logic [31:0] exp_l);
    @(negedge clk);
    z_addr = addr; z_store = store; z_ren = ren; z_wen = wen;
    #1;
    chk({tag, ".state"}, {30'd0, z_state}, {30'd0, exp_s});
    chk({tag, ".load"}, z_load, exp_l);
  endtask

  initial begin
    nrst = 1'b0;
    a_addr = 32'd0; a_store = 32'd0; a_ren = 1'b0; a_wen = 1'b0;
    z_addr = 32'd0; z_store = 32'd0; z_ren = 1'b0; z_wen = 1'b0;
    #2;
    chk("rst.state", {30'd0, a_state}, {30'd0, S_FREE});
    chk("rst.load", a_load, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    a_cyc("idle0", 32'd0, 32'd0, 1'b0, 1'b0, S_FREE, 32'd0);
    a_cyc("idle1", 32'd0, 32'd0, 1'b0, 1'b0, S_FREE, 32'd0);

    // Write 0x40 then read it back, LAT=2.
    a_cyc("wr40.c0", 32'h40, 32'hDEADBEEF, 1'b0, 1'b1, S_BUSY, 32'd0);
    a_cyc("wr40.c1", 32'h40, 32'hDEADBEEF, 1'b0, 1'b1, S_BUSY, 32'd0);
    a_cyc("wr40.c2", 32'h40, 32'hDEADBEEF, 1'b0, 1'b1, S_ACCESS, 32'd0);
    a_cyc("rd40.c0", 32'h40, 32'd0, 1'b1, 1'b0, S_BUSY, 32'd0);
    a_cyc("rd40.c1", 32'h40, 32'd0, 1'b1, 1'b0, S_BUSY, 32'd0);
    a_cyc("rd40.c2", 32'h40, 32'd0, 1'b1, 1'b0, S_ACCESS, 32'hDEADBEEF);

    // Preload 0x44 and 0x80.
    a_cyc("wr44.c0", 32'h44, 32'h12345678, 1'b0, 1'b1, S_BUSY, 32'd0);
    a_cyc("wr44.c1", 32'h44, 32'h12345678, 1'b0, 1'b1, S_BUSY, 32'd0);
    a_cyc("wr44.c2", 32'h44, 32'h12345678, 1'b0, 1'b1, S_ACCESS, 32'd0);
    a_cyc("wr80.c0", 32'h80, 32'hCAFEF00D, 1'b0, 1'b1, S_BUSY, 32'd0);
    a_cyc("wr80.c1", 32'h80, 32'hCAFEF00D, 1'b0, 1'b1, S_BUSY, 32'd0);
    a_cyc("wr80.c2", 32'h80, 32'hCAFEF00D, 1'b0, 1'b1, S_ACCESS, 32'd0);

    // Address switch mid-BUSY restarts the latency.
    a_cyc("sw.c0", 32'h40, 32'd0, 1'b1, 1'b0, S_BUSY, 32'd0);
    a_cyc("sw.c1", 32'h44, 32'd0, 1'b1, 1'b0, S_BUSY, 32'd0);
    a_cyc("sw.c2", 32'h44, 32'd0, 1'b1, 1'b0, S_BUSY, 32'd0);
    a_cyc("sw.c3", 32'h44, 32'd0, 1'b1, 1'b0, S_ACCESS, 32'h12345678);

    // Simultaneous REN and WEN is an error and must not write.
    a_cyc("both.c0", 32'h80, 32'h00000BAD, 1'b1, 1'b1, S_ERROR, 32'd0);
    a_cyc("both.c1", 32'h80, 32'h00000BAD, 1'b1, 1'b1, S_ERROR, 32'd0);
    a_cyc("both.c2", 32'h80, 32'h00000BAD, 1'b1, 1'b1, S_ERROR, 32'd0);
    a_cyc("rd80.c0", 32'h80, 32'd0, 1'b1, 1'b0, S_BUSY, 32'd0);
    a_cyc("rd80.c1", 32'h80, 32'd0, 1'b1, 1'b0, S_BUSY, 32'd0);
    a_cyc("rd80.c2", 32'h80, 32'd0, 1'b1, 1'b0, S_ACCESS, 32'hCAFEF00D);

    // Dropped request discards the count.
    a_cyc("drop.c0", 32'h40, 32'd0, 1'b1, 1'b0, S_BUSY, 32'd0);
    a_cyc("drop.c1", 32'h40, 32'd0, 1'b0, 1'b0, S_FREE, 32'd0);
    a_cyc("drop.c2", 32'h40, 32'd0, 1'b1, 1'b0, S_BUSY, 32'd0);
    a_cyc("drop.c3", 32'h40, 32'd0, 1'b1, 1'b0, S_BUSY, 32'd0);
    a_cyc("drop.c4", 32'h40, 32'd0, 1'b1, 1'b0, S_ACCESS, 32'hDEADBEEF);

    // Upper address bits set.
    a_cyc("hi.c0", 32'h0010_0000, 32'd0, 1'b1, 1'b0, S_ERROR, 32'd0);

    // Reset during a write's ACCESS cycle suppresses the write.
    a_cyc("rw.c0", 32'h40, 32'h11111111, 1'b0, 1'b1, S_BUSY, 32'd0);
    a_cyc("rw.c1", 32'h40, 32'h11111111, 1'b0, 1'b1, S_BUSY, 32'd0);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("rw.rst.state", {30'd0, a_state}, {30'd0, S_FREE});
    @(negedge clk);
    nrst = 1'b1;
    a_cyc("rw.rd.c0", 32'h40, 32'd0, 1'b1, 1'b0, S_BUSY, 32'd0);
    a_cyc("rw.rd.c1", 32'h40, 32'd0, 1'b1, 1'b0, S_BUSY, 32'd0);
    a_cyc("rw.rd.c2", 32'h40, 32'd0, 1'b1, 1'b0, S_ACCESS, 32'hDEADBEEF);

    // Misaligned read.
`ifdef RAM_ALIGN_CHECK_EN
    a_cyc("mis.c0", 32'h42, 32'd0, 1'b1, 1'b0, S_ERROR, 32'd0);
    a_cyc("mis.c1", 32'h42, 32'd0, 1'b1, 1'b0, S_ERROR, 32'd0);
`else
    a_cyc("mis.c0", 32'h42, 32'd0, 1'b1, 1'b0, S_BUSY, 32'd0);
    a_cyc("mis.c1", 32'h42, 32'd0, 1'b1, 1'b0, S_BUSY, 32'd0);
    a_cyc("mis.c2", 32'h42, 32'd0, 1'b1, 1'b0, S_ACCESS, 32'hDEADBEEF);
`endif
    a_cyc("idle2", 32'd0, 32'd0, 1'b0, 1'b0, S_FREE, 32'd0);

    // LAT=0: immediate ACCESS, read-after-write, held request.
    z_cyc("z.wr40", 32'h40, 32'hA5A5A5A5, 1'b0, 1'b1, S_ACCESS, 32'd0);
    z_cyc("z.rd40.c0", 32'h40, 32'd0, 1'b1, 1'b0, S_ACCESS, 32'hA5A5A5A5);
    z_cyc("z.rd40.c1", 32'h40, 32'd0, 1'b1, 1'b0, S_ACCESS, 32'hA5A5A5A5);
    z_cyc("z.rd40.c2", 32'h40, 32'd0, 1'b1, 1'b0, S_ACCESS, 32'hA5A5A5A5);
    z_cyc("z.hi", 32'h0010_0000, 32'd0, 1'b1, 1'b0, S_ERROR, 32'd0);
    z_cyc("z.both", 32'h40, 32'h0, 1'b1, 1'b1, S_ERROR, 32'd0);
    z_cyc("z.idle", 32'd0, 32'd0, 1'b0, 1'b0, S_FREE, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
